photon_acq_sequencer: RTL
=========================

# photon_acq_sequencer

Run controller for the photon counting datapath. It latches the host-requested count period, releases the counter from reset for a bounded or continuous acquisition of N count periods, and serialises each 64-bit count result into 32-bit words for the host-bound FIFO. It sits between the register interface, `photon_cnt_output`'s counter and the FIFO write port. It also owns FIFO backpressure and the dropped-frame accounting.

## Interface
- `COUNTSIZE`, 32: width of one count field and of the count period.
- `FRAME_W`, 16: width of the frame count and of the frame index.
- `c_clk`  in  1: sole clock.
- `c_rst_n`  in  1: reset, asynchronous assert, active-low.
- `c_start`  in  1: one-cycle pulse that starts a run; ignored while `c_busy`.
- `c_abort`  in  1: one-cycle pulse that terminates a run immediately.
- `c_num_frames`  in  FRAME_W: periods per run; 0 means continuous until abort.
- `c_count_period_cfg`  in  COUNTSIZE: requested count period from the host register.
- `c_count_period`  out  COUNTSIZE: period latched at start and driven to the counter.
- `c_counter_rst`  out  1: active-high reset to the counter datapath.
- `c_cnt_ready`  in  1: one-cycle result strobe from the counter.
- `c_ch1_cnt_output`  in  2*COUNTSIZE: result, {raw count, lock-in count}.
- `c_fifo_din`  out  32: FIFO write data.
- `c_fifo_wr_en`  out  1: FIFO write strobe.
- `c_fifo_full`  in  1: FIFO full flag.
- `c_busy`  out  1: high from the ARM state through the DRAIN state.
- `c_done`  out  1: one-cycle pulse on normal run completion.
- `c_overflow_cnt`  out  16: dropped frames in the current or last run; saturates at 0xFFFF.

## Operation
- **Reset values:** state IDLE; `c_counter_rst`=1; every other output 0.
- **FSM states:** IDLE, ARM, RUN, DRAIN, DONE.
- **IDLE:**
  - `c_counter_rst`=1.
  - On `c_start`: latch `c_count_period_cfg` into `c_count_period`, latch `c_num_frames`, clear the frame counter and `c_overflow_cnt`, then go to ARM.
- **ARM:** hold `c_counter_rst`=1 for exactly 2 cycles, then go to RUN. In RUN, `c_counter_rst`=0.
- **RUN, per `c_cnt_ready`:**
  - Increment the frame counter.
  - If the serialiser is empty, load `c_ch1_cnt_output` into it.
  - Otherwise drop the frame and increment `c_overflow_cnt`, saturating.
  - When the frame counter reaches the latched `c_num_frames` (nonzero), go to DRAIN and assert `c_counter_rst`.
- **DRAIN:** wait until the serialiser is empty, then go to DONE.
- **DONE:** `c_done`=1 for one cycle, then go to IDLE.
- **Abort:**
  - `c_abort` in ARM, RUN or DRAIN discards the serialiser contents and goes to IDLE next cycle.
  - No `c_done` pulse is generated.
  - `c_overflow_cnt` is retained.
  - If `c_abort` and `c_start` arrive in the same cycle while IDLE, `c_start` wins.
- **Serialiser:**
  - Word order: raw count [2*COUNTSIZE-1:COUNTSIZE], then lock-in count [COUNTSIZE-1:0].
  - `c_fifo_wr_en` = pending word AND !`c_fifo_full`. It is combinational from registered state and the full flag.
  - `c_fifo_din` is registered.
  - A word advances only on a cycle with `c_fifo_wr_en`=1.
- **Simultaneous load and emit:** a `c_cnt_ready` on the same cycle as the last word's write is accepted and not dropped.
- **Frame counter** is FRAME_W wide. In continuous mode it wraps at 2^FRAME_W without effect on control.
- **Reset mid-run** returns to IDLE with reset values. Partial frames are lost.

## Timing
- **Start:** `c_start` at cycle 0, then `c_busy`=1 at cycle 1, `c_counter_rst` low from cycle 3.
- **Result to FIFO, FIFO not full:**
  - First word written 1 cycle after `c_cnt_ready`.
  - Consecutive words are written on consecutive cycles.
- **Completion:** `c_done` pulses 1 cycle after the last word is written. `c_busy` is low on the following cycle.

## Configuration
- **`PHOTON_SEQ_HEADER_EN` defined:**
  - Each frame is prefixed by a header word {16'hA5A5, frame index[15:0]}, so frames are 3 words.
  - The frame index starts at 0 each run.
  - If FRAME_W>16, the index is truncated to 16 bits.
- **Not defined:** 2 words per frame, no header logic.

## Structure
- **Shared package `photon_pkg`:**
  - FSM state enum.
  - Header magic 16'hA5A5.
  - ARM hold length 2.
  - Overflow counter width 16.
- **One sub-module, `photon_word_serializer`:** holding register, word index and FIFO handshake. The FSM stays in the top.

## Test plan
- **Bounded run:** num_frames=3, period=100, FIFO never full → 6 words in raw/lock-in order, `c_done` once, `c_overflow_cnt`=0.
- **Backpressure:** `c_fifo_full` held high for 250 cycles during a run with period=100 → 2 frames dropped, `c_overflow_cnt`=2, delivered words intact and in order.
- **Abort mid-DRAIN** with 1 word pending → no further writes, no `c_done`, IDLE and `c_counter_rst`=1 the next cycle.
- **Continuous mode:** num_frames=0 for 10 periods, then abort → 20 words; `c_start` pulses during the run are ignored.
- **Header build:** with `PHOTON_SEQ_HEADER_EN`, num_frames=2 → words A5A5_0000, raw, lck, A5A5_0001, raw, lck.
- **Async reset:** `c_rst_n` low mid-RUN → all outputs at reset values immediately (0, and `c_counter_rst`=1); a new `c_start` after release runs normally.

Source files
------------

// File: rtl/photon_pkg.sv
// Shared types and constants for the photon acquisition sequencer.
// PHOTON_SEQ_HEADER_EN adds a header word in front of every frame.
package photon_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [15:0] HDR_MAGIC = 16'hA5A5;
    localparam int ARM_HOLD = 2;
    localparam int OVF_W = 16;

`ifdef PHOTON_SEQ_HEADER_EN
    localparam int WORDS_PER_FRAME = 3;
`else
    localparam int WORDS_PER_FRAME = 2;
`endif

endpackage

// File: rtl/photon_word_serializer.sv
// Splits one count result into 32-bit FIFO words.
// PHOTON_SEQ_HEADER_EN prefixes each frame with {HDR_MAGIC, frame index}.
module photon_word_serializer
    import photon_pkg::*;
#(
    parameter int COUNTSIZE = 32
) (
    input  logic                   c_clk,
    input  logic                   c_rst_n,
    input  logic                   load,
    input  logic                   flush,
    input  logic [2*COUNTSIZE-1:0] frame,
`ifdef PHOTON_SEQ_HEADER_EN
    input  logic [15:0]            frame_idx,
`endif
    input  logic                   fifo_full,
    output logic [31:0]            fifo_din,
    output logic                   fifo_wr_en,
    output logic                   can_load
);

    logic [1:0]  left;
    logic [31:0] next0;
`ifdef PHOTON_SEQ_HEADER_EN
    logic [31:0] next1;
`endif

    assign fifo_wr_en = (left != 2'd0) && !fifo_full;
    // Empty now, or the final word leaves this cycle.
    assign can_load = (left == 2'd0) || ((left == 2'd1) && fifo_wr_en);

    // Word shift register: fifo_din always holds the word on offer.
    always_ff @(posedge c_clk or negedge c_rst_n) begin
        if (!c_rst_n) begin
            left     <= 2'd0;
            fifo_din <= 32'd0;
            next0    <= 32'd0;
`ifdef PHOTON_SEQ_HEADER_EN
            next1    <= 32'd0;
`endif
        end else if (flush) begin
            left <= 2'd0;
        end else if (load) begin
            left <= 2'(WORDS_PER_FRAME);
`ifdef PHOTON_SEQ_HEADER_EN
            fifo_din <= {HDR_MAGIC, frame_idx};
            next0    <= frame[2*COUNTSIZE-1:COUNTSIZE];
            next1    <= frame[COUNTSIZE-1:0];
`else
            fifo_din <= frame[2*COUNTSIZE-1:COUNTSIZE];
            next0    <= frame[COUNTSIZE-1:0];
`endif
        end else if (fifo_wr_en) begin
            left     <= left - 2'd1;
            fifo_din <= next0;
`ifdef PHOTON_SEQ_HEADER_EN
            next0    <= next1;
`endif
        end
    end

endmodule

// File: rtl/photon_acq_sequencer.sv
// Run controller: arms the counter, collects N results, feeds the FIFO.
// PHOTON_SEQ_HEADER_EN selects 3-word frames with a header word.
module photon_acq_sequencer
    import photon_pkg::*;
#(
    parameter int COUNTSIZE = 32,
    parameter int FRAME_W   = 16
) (
    input  logic                   c_clk,
    input  logic                   c_rst_n,
    input  logic                   c_start,
    input  logic                   c_abort,
    input  logic [FRAME_W-1:0]     c_num_frames,
    input  logic [COUNTSIZE-1:0]   c_count_period_cfg,
    output logic [COUNTSIZE-1:0]   c_count_period,
    output logic                   c_counter_rst,
    input  logic                   c_cnt_ready,
    input  logic [2*COUNTSIZE-1:0] c_ch1_cnt_output,
    output logic [31:0]            c_fifo_din,
    output logic                   c_fifo_wr_en,
    input  logic                   c_fifo_full,
    output logic                   c_busy,
    output logic                   c_done,
    output logic [OVF_W-1:0]       c_overflow_cnt
);

    state_t               state;
    state_t               state_nx;
    logic [1:0]           arm_cnt;
    logic [FRAME_W-1:0]   frames_lat;
    logic [FRAME_W-1:0]   frame_cnt;
    logic                 ser_can_load;
    logic                 frame_evt;
    logic                 last_frame;
    logic                 ser_load;
    logic                 ser_flush;

    assign frame_evt  = (state == S_RUN) && c_cnt_ready && !c_abort;
    assign last_frame = (frames_lat != '0) &&
                        (frame_cnt + FRAME_W'(1) == frames_lat);
    assign ser_load   = frame_evt && ser_can_load;
    assign ser_flush  = c_abort && c_busy;

    // State register.
    always_ff @(posedge c_clk or negedge c_rst_n) begin
        if (!c_rst_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    // Next state and state-decoded outputs.
    always_comb begin
        state_nx      = state;
        c_busy        = 1'b0;
        c_done        = 1'b0;
        c_counter_rst = 1'b1;
        unique case (state)
            S_IDLE: begin
                if (c_start) state_nx = S_ARM;
            end
            S_ARM: begin
                c_busy = 1'b1;
                if (c_abort)
                    state_nx = S_IDLE;
                else if (arm_cnt == 2'(ARM_HOLD - 1))
                    state_nx = S_RUN;
            end
            S_RUN: begin
                c_busy        = 1'b1;
                c_counter_rst = 1'b0;
                if (c_abort)
                    state_nx = S_IDLE;
                else if (c_cnt_ready && last_frame)
                    state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                c_busy = 1'b1;
                if (c_abort)
                    state_nx = S_IDLE;
                else if (ser_can_load)
                    state_nx = S_DONE;
            end
            S_DONE: begin
                c_done   = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Run configuration, frame counting and drop accounting.
    always_ff @(posedge c_clk or negedge c_rst_n) begin
        if (!c_rst_n) begin
            c_count_period <= '0;
            frames_lat     <= '0;
            frame_cnt      <= '0;
            c_overflow_cnt <= '0;
            arm_cnt        <= 2'd0;
        end else begin
            if (state == S_IDLE && c_start) begin
                c_count_period <= c_count_period_cfg;
                frames_lat     <= c_num_frames;
                frame_cnt      <= '0;
                c_overflow_cnt <= '0;
                arm_cnt        <= 2'd0;
            end
            if (state == S_ARM)
                arm_cnt <= arm_cnt + 2'd1;
            if (frame_evt) begin
                frame_cnt <= frame_cnt + FRAME_W'(1);
                if (!ser_can_load && c_overflow_cnt != '1)
                    c_overflow_cnt <= c_overflow_cnt + OVF_W'(1);
            end
        end
    end

    photon_word_serializer #(
        .COUNTSIZE (COUNTSIZE)
    ) u_ser (
        .c_clk      (c_clk),
        .c_rst_n    (c_rst_n),
        .load       (ser_load),
        .flush      (ser_flush),
        .frame      (c_ch1_cnt_output),
`ifdef PHOTON_SEQ_HEADER_EN
        .frame_idx  (16'(frame_cnt)),
`endif
        .fifo_full  (c_fifo_full),
        .fifo_din   (c_fifo_din),
        .fifo_wr_en (c_fifo_wr_en),
        .can_load   (ser_can_load)
    );

endmodule
